// File: rtl/dotp_pkg.sv
// Shared definitions for the dot-product engine: FSM state encoding,
// default element width / vector length, and a small width helper.
package dotp_pkg;

  localparam int DOTP_DATA_W  = 32;
  localparam int DOTP_MAX_LEN = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dotp_state_e;

  function automatic int dotp_max(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/dotp_mac_lane.sv
// One multiply lane of the dot-product engine: extends both operands for
// the active mode, multiplies, masks lanes beyond the vector length and
// registers the 2*DATA_W-bit product.
module dotp_mac_lane #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  lane_en,
  input  logic                  signed_mode,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   prod
);

  localparam int PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] a_w;
  logic [PROD_W-1:0] b_w;
  logic [PROD_W-1:0] full;
  logic [PROD_W-1:0] prod_d;
  logic [PROD_W-1:0] prod_q;

  // Extend to product width first; the low PROD_W bits of the product are exact in both modes.
  always_comb begin
    a_w    = signed_mode ? PROD_W'($signed(a)) : PROD_W'(a);
    b_w    = signed_mode ? PROD_W'($signed(b)) : PROD_W'(b);
    full   = a_w * b_w;
    prod_d = prod_q;
    if (load) begin
      prod_d = lane_en ? full : '0;
    end
  end

  // Product pipeline register, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign prod = prod_q;

endmodule

// File: rtl/dot_product_engine.sv
// Streaming dot-product engine: accepts LANES element pairs per beat,
// multiplies them in a registered lane stage, and accumulates into an
// ACC_W-bit result reported with a one-cycle done pulse.
// Build option: define DOTP_SAT_EN to clamp each accumulator update to the
// ACC_W range of the active mode and raise a sticky overflow flag; without
// it the accumulator wraps and overflow stays 0.
module dot_product_engine
  import dotp_pkg::*;
#(
  parameter int DATA_W  = DOTP_DATA_W,
  parameter int MAX_LEN = DOTP_MAX_LEN,
  parameter int LANES   = 2,
  parameter int ACC_W   = 2 * DATA_W + $clog2(MAX_LEN) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [$clog2(MAX_LEN+1)-1:0]   len,
  input  logic                           signed_mode,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES*DATA_W-1:0]        a_data,
  input  logic [LANES*DATA_W-1:0]        b_data,
  output logic                           busy,
  output logic                           done,
  output logic [ACC_W-1:0]               result,
  output logic                           overflow
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int PROD_W = 2 * DATA_W;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LANES_L   = LEN_W'(LANES);

`ifdef DOTP_SAT_EN
  // Two guard bits above the widest operand so clamping sees the true sum.
  localparam int SUM_W  = PROD_W + $clog2(LANES + 1) + 1;
  localparam int CALC_W = dotp_max(SUM_W, ACC_W) + 2;
  localparam logic signed [CALC_W-1:0] ONE_C = CALC_W'(1);
  localparam logic signed [CALC_W-1:0] S_MAX = (ONE_C <<< (ACC_W - 1)) - ONE_C;
  localparam logic signed [CALC_W-1:0] S_MIN = -(ONE_C <<< (ACC_W - 1));
  localparam logic signed [CALC_W-1:0] U_MAX = (ONE_C <<< ACC_W) - ONE_C;
`else
  localparam int CALC_W = ACC_W;
`endif

  dotp_state_e state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d, len_c;
  logic              sm_q, sm_d;
  logic              pv_q, pv_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;
  logic              clr;

  logic [LANES-1:0]             lane_en;
  logic [LANES-1:0][PROD_W-1:0] prod;
  logic [CALC_W-1:0]            lane_sum;
  logic [CALC_W-1:0]            acc_ext;
  logic [CALC_W-1:0]            total;

  assign accept = in_valid & in_ready_q;
  assign len_c  = (len > MAX_LEN_L) ? MAX_LEN_L : len;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    // Lane g carries a real element only while that many elements remain.
    assign lane_en[g] = (rem_q > LEN_W'(g));

    dotp_mac_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .load        (accept),
      .lane_en     (lane_en[g]),
      .signed_mode (sm_q),
      .a           (a_data[g*DATA_W +: DATA_W]),
      .b           (b_data[g*DATA_W +: DATA_W]),
      .prod        (prod[g])
    );
  end

  // Next-state, remaining-element count and registered handshake/status outputs.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sm_d    = sm_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          rem_d   = len_c;
          sm_d    = signed_mode;
          clr     = 1'b1;
        end
      end
      LOAD: begin
        if (rem_q == '0) begin
          state_d = DONE;
        end else if (accept) begin
          if (rem_q <= LANES_L) begin
            rem_d   = '0;
            state_d = DRAIN;
          end else begin
            rem_d = rem_q - LANES_L;
          end
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // in_ready is withheld for a zero-length operation so no beat is taken.
    in_ready_d = (state_d == LOAD) && (rem_d != '0);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    pv_d       = accept;
  end

  // Lane sum and accumulator update; result captured as the last products land.
  always_comb begin
    lane_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + (sm_q ? CALC_W'($signed(prod[i])) : CALC_W'(prod[i]));
    end
    acc_ext  = sm_q ? CALC_W'($signed(acc_q)) : CALC_W'(acc_q);
    total    = acc_ext + lane_sum;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    if (clr) begin
      acc_d    = '0;
      ovf_d    = 1'b0;
      result_d = '0;
    end else begin
      if (pv_q) begin
`ifdef DOTP_SAT_EN
        if (sm_q) begin
          if ($signed(total) > S_MAX) begin
            acc_d = S_MAX[ACC_W-1:0];
            ovf_d = 1'b1;
          end else if ($signed(total) < S_MIN) begin
            acc_d = S_MIN[ACC_W-1:0];
            ovf_d = 1'b1;
          end else begin
            acc_d = total[ACC_W-1:0];
          end
        end else begin
          if ($signed(total) > U_MAX) begin
            acc_d = U_MAX[ACC_W-1:0];
            ovf_d = 1'b1;
          end else begin
            acc_d = total[ACC_W-1:0];
          end
        end
`else
        acc_d = total[ACC_W-1:0];
`endif
      end
      if (state_q == DRAIN) begin
        result_d = acc_d;
      end
    end
  end

  // All engine state, cleared asynchronously so an aborted run leaves nothing behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      sm_q       <= 1'b0;
      pv_q       <= 1'b0;
      acc_q      <= '0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      sm_q       <= sm_d;
      pv_q       <= pv_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Scoreboard bench for dot_product_engine: a default-width instance and a
// 16-bit-accumulator instance share the same stimulus; expected results come
// from a wide-integer reference model and are checked by a separate monitor.
module tb_dot_product_engine;

  localparam int DW   = 32;
  localparam int ML   = 8;
  localparam int LN   = 2;
  localparam int LW   = $clog2(ML + 1);
  localparam int AW   = 2 * DW + $clog2(ML) + 1;
  localparam int AW16 = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LW-1:0]     len;
  logic              signed_mode;
  logic              in_valid;
  logic [LN*DW-1:0]  a_data, b_data;
  logic              in_ready, busy, done, overflow;
  logic [AW-1:0]     result;
  logic              in_ready16, busy16, done16, overflow16;
  logic [AW16-1:0]   result16;

  dot_product_engine #(
    .DATA_W (DW), .MAX_LEN (ML), .LANES (LN)
  ) u_dut (
    .clk (clk), .rst (rst), .start (start), .len (len), .signed_mode (signed_mode),
    .in_valid (in_valid), .in_ready (in_ready), .a_data (a_data), .b_data (b_data),
    .busy (busy), .done (done), .result (result), .overflow (overflow)
  );

  dot_product_engine #(
    .DATA_W (DW), .MAX_LEN (ML), .LANES (LN), .ACC_W (AW16)
  ) u_dut16 (
    .clk (clk), .rst (rst), .start (start), .len (len), .signed_mode (signed_mode),
    .in_valid (in_valid), .in_ready (in_ready16), .a_data (a_data), .b_data (b_data),
    .busy (busy16), .done (done16), .result (result16), .overflow (overflow16)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]   r;
    logic            o;
    logic [AW16-1:0] r16;
    logic            o16;
    int              beats;
  } exp_t;

  exp_t          exp_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  int            beat_cnt = 0;
  int            last_acc = 0;
  logic [AW-1:0]   last_r;
  logic            last_o;
  logic [AW16-1:0] last_r16;
  logic            last_o16;
  logic [31:0]   av[ML];
  logic [31:0]   bv[ML];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] s68(input longint v);
    return AW'(v);
  endfunction

  function automatic logic signed [127:0] ext(input logic [31:0] x, input bit sm);
    return sm ? {{96{x[31]}}, x} : {96'b0, x};
  endfunction

  // Reference: per-beat sums of exact products; optional clamp after each beat.
  function automatic void model_acc(input int w, input bit sm, input int n,
                                    output logic [127:0] r, output logic o);
    logic signed [127:0] acc, s;
`ifdef DOTP_SAT_EN
    logic signed [127:0] hi, lo;
    hi = sm ? ((128'sd1 <<< (w - 1)) - 128'sd1) : ((128'sd1 <<< w) - 128'sd1);
    lo = sm ? -(128'sd1 <<< (w - 1)) : 128'sd0;
`endif
    acc = 0;
    o   = 1'b0;
    for (int bt = 0; bt * LN < n; bt++) begin
      s = 0;
      for (int l = 0; l < LN; l++)
        if (bt * LN + l < n) s += ext(av[bt*LN+l], sm) * ext(bv[bt*LN+l], sm);
      acc += s;
`ifdef DOTP_SAT_EN
      if (acc > hi) begin acc = hi; o = 1'b1; end
      else if (acc < lo) begin acc = lo; o = 1'b1; end
`endif
    end
    r = acc;
  endfunction

  task automatic fill_rand();
    int k;
    for (int i = 0; i < ML; i++) begin
      k = $urandom_range(2);
      if (k == 0) begin av[i] = $urandom(); bv[i] = $urandom(); end
      else if (k == 1) begin
        av[i] = $urandom_range(200) - 100;
        bv[i] = $urandom_range(200) - 100;
      end else begin
        av[i] = ($urandom_range(1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        bv[i] = ($urandom_range(1) == 1) ? 32'hFFFF_FFFF : 32'h8000_0000;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_busy16"}, busy16, 0);
    chk({tag, "_result16"}, result16, 0);
  endtask

  task automatic drive_beat(input int bi, input int gap_pct);
    int  idx, t;
    bit  got;
    for (int l = 0; l < LN; l++) begin
      idx = bi * LN + l;
      a_data[l*DW +: DW] = (idx < ML) ? av[idx] : $urandom();
      b_data[l*DW +: DW] = (idx < ML) ? bv[idx] : $urandom();
    end
    while ($urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk); got = in_ready;
      @(posedge clk); #1; t++;
    end while (!got && t < 200);
    if (!got) chk("beat_accept_timeout", 0, 1);
    in_valid = 1'b0;
    a_data = {$urandom(), $urandom()};
    b_data = {$urandom(), $urandom()};
  endtask

  task automatic run_op(input int n_req, input bit sm, input int gap_pct, input bit start_in_done);
    int          n, beats, t;
    exp_t        e;
    logic [127:0] r;
    n     = (n_req > ML) ? ML : n_req;
    beats = (n + LN - 1) / LN;
    model_acc(AW, sm, n, r, e.o);     e.r   = r[AW-1:0];
    model_acc(AW16, sm, n, r, e.o16); e.r16 = r[AW16-1:0];
    e.beats = beats;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b1; len = LW'(n_req); signed_mode = sm;
    @(posedge clk); #1;
    start = 1'b0; len = LW'($urandom_range(15)); signed_mode = ~sm;
    for (int bi = 0; bi < beats; bi++) drive_beat(bi, gap_pct);
    t = 0;
    do begin @(negedge clk); t++; end while (!done && t < 60);
    if (!done) chk("done_timeout", 0, 1);
    if (start_in_done) begin
      start = 1'b1; len = LW'(3);
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      chk("start_in_done_ignored", busy, 0);
    end
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard whenever either engine raises done.
  always @(negedge clk) begin
    if (rst) begin
      if (start && !busy) beat_cnt = 0;
      if (in_valid && in_ready) begin beat_cnt++; last_acc = cyc; end
      if (done || done16) begin
        chk("done_pair", done16, done);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result", result, e.r);
          chk("overflow", overflow, e.o);
          chk("result16", result16, e.r16);
          chk("overflow16", overflow16, e.o16);
          chk("beats_accepted", beat_cnt, e.beats);
          if (e.beats > 0) chk("done_latency", cyc - last_acc, 2);
          last_r = result; last_o = overflow; last_r16 = result16; last_o16 = overflow16;
        end
        beat_cnt = 0;
      end
    end
  end

  initial begin
    int dcount;
    rst = 1'b0; start = 1'b0; len = '0; signed_mode = 1'b0; in_valid = 1'b0;
    a_data = '0; b_data = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b1;

    av = '{1, 2, 3, 4, 5, 6, 7, 8};
    bv = '{10, 10, 10, 10, 1, 1, 1, 1};
    run_op(8, 1'b1, 0, 1'b0);
    chk("req039_result", last_r, 126);
    chk("req039_overflow", last_o, 0);

    av = '{10, -5, 100, -1, 0, 20, -2, 1};
    bv = '{2, 10, -1, 20, 50, -5, 4, -8};
    run_op(8, 1'b1, 0, 1'b0);
    chk("req040_result", last_r, s68(-266));
    chk("req040_overflow", last_o, 0);

    av = '{1, 2, 3, 4, 5, 99, 7, 7};
    bv = '{1, 2, 3, 4, 5, 99, 7, 7};
    run_op(5, 1'b0, 0, 1'b0);
    chk("req041_masked", last_r, 55);

    fill_rand();
    run_op(0, 1'b1, 0, 1'b1);
    chk("len0_result", last_r, 0);

    fill_rand(); av[0] = 32'hFFFF_FFFF; bv[0] = 32'd2;
    run_op(1, 1'b0, 0, 1'b0);
    chk("req042_unsigned", last_r, 68'h1_FFFF_FFFE);
    run_op(1, 1'b1, 0, 1'b0);
    chk("req042_signed", last_r, s68(-2));

    fill_rand(); av[0] = 200; av[1] = 200; bv[0] = 200; bv[1] = 200;
    run_op(2, 1'b1, 0, 1'b0);
    chk("req043_wide", last_r, 80000);
`ifdef DOTP_SAT_EN
    chk("req043_acc16", last_r16, 32767);
    chk("req043_ovf16", last_o16, 1);
`else
    chk("req043_acc16", last_r16, 14464);
    chk("req043_ovf16", last_o16, 0);
`endif

    for (int k = 0; k < 40; k++) begin
      fill_rand();
      run_op($urandom_range(15), $urandom_range(1), $urandom_range(50), $urandom_range(1));
    end

    // Abort mid-operation: two beats in, then asynchronous reset.
    fill_rand();
    @(posedge clk); #1 start = 1'b1; len = LW'(8); signed_mode = 1'b1;
    @(posedge clk); #1 start = 1'b0; in_valid = 1'b1;
    a_data = {av[1], av[0]}; b_data = {bv[1], bv[0]};
    @(posedge clk); #1 a_data = {av[3], av[2]}; b_data = {bv[3], bv[2]};
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", busy, 1);
    #2 rst = 1'b0;
    @(negedge clk);
    check_all_zero("abort");
    @(posedge clk); #1 rst = 1'b1;
    dcount = 0;
    repeat (10) begin @(negedge clk); if (done || done16) dcount++; end
    chk("abort_no_done", dcount, 0);
    check_all_zero("abort_idle");

    av = '{1, 2, 3, 4, 5, 6, 7, 8};
    bv = '{10, 10, 10, 10, 1, 1, 1, 1};
    run_op(8, 1'b1, 40, 1'b0);
    chk("req044_result", last_r, 126);

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dot_product_engine.md
DOT_PRODUCT_ENGINE -- requirements
Module: dot_product_engine

Interface
REQ-001 Parameter DATA_W, default 32: width of each signed or unsigned vector element.
REQ-002 Parameter MAX_LEN, default 8: maximum vector length per operation.
REQ-003 Parameter LANES, default 2: element pairs accepted per input beat (1..MAX_LEN).
REQ-004 Parameter ACC_W, default 2*DATA_W+$clog2(MAX_LEN)+1: accumulator and result width.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous assert, active-low.
REQ-007 start  in  1  one-cycle request to begin an operation; ignored unless idle.
REQ-008 len  in  $clog2(MAX_LEN+1)  element count, sampled on accepted start.
REQ-009 signed_mode  in  1  1 = signed operands, 0 = unsigned; sampled on accepted start.
REQ-010 in_valid  in  1  a_data/b_data hold a valid beat.
REQ-011 in_ready  out  1  engine accepts a beat this cycle.
REQ-012 a_data, b_data  in  LANES*DATA_W  packed elements; lane 0 in the LSBs.
REQ-013 busy  out  1  an operation is in progress.
REQ-014 done  out  1  one-cycle pulse when result is final.
REQ-015 result  out  ACC_W  dot product; held until the next accepted start.
REQ-016 overflow  out  1  sticky saturation flag for the current result.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, DRAIN and DONE.
REQ-018 IDLE SHALL move to LOAD on start; the accumulator, result and overflow SHALL clear in that transition.
REQ-019 In LOAD, in_ready SHALL be 1, and a beat SHALL be accepted on each cycle where in_valid and in_ready are both 1.
REQ-020 Beats required per operation SHALL be ceil(len/LANES).
REQ-021 On the final beat, lanes with index >= len-(beats-1)*LANES SHALL contribute 0, regardless of their data.
REQ-022 Each lane product SHALL be 2*DATA_W wide, registered in one pipeline stage, summed across lanes, then added into the accumulator.
REQ-023 Operands SHALL be sign-extended when signed_mode=1 and zero-extended when signed_mode=0.
REQ-024 After the last beat is accepted, the FSM SHALL go to DRAIN (one cycle) and then DONE.
REQ-025 done SHALL be high exactly in the second cycle after the last-beat edge, and result SHALL be final in that same cycle.
REQ-026 DONE SHALL last one cycle and then return to IDLE.
REQ-027 With len=0, the FSM SHALL go from LOAD directly to DONE without accepting a beat, and result SHALL be 0.
REQ-028 len>MAX_LEN SHALL be clamped to MAX_LEN.
REQ-029 busy SHALL be 1 in LOAD, DRAIN and DONE; in_ready SHALL be 0 outside LOAD.
REQ-030 start while busy SHALL be ignored; start in the DONE cycle SHALL also be ignored.
REQ-031 Gaps in in_valid SHALL stall LOAD without corrupting the accumulator.

Reset
REQ-032 While rst=0, the FSM SHALL be in IDLE and in_ready, busy, done, result and overflow SHALL all be 0.
REQ-033 The pipeline and accumulator SHALL clear on reset, including reset asserted mid-operation; no done SHALL follow.

Configuration
REQ-034 Macro DOTP_SAT_EN defined: each accumulator update SHALL clamp to the ACC_W range for the active mode and set overflow sticky on any clamp.
REQ-035 Signed clamp limits SHALL be -2^(ACC_W-1) and 2^(ACC_W-1)-1; the unsigned clamp limit SHALL be 2^ACC_W-1.
REQ-036 Macro DOTP_SAT_EN undefined: accumulation SHALL wrap modulo 2^ACC_W, and overflow SHALL be tied to 0.

Structure
REQ-037 Package dotp_pkg SHALL hold the FSM state enum and the default DATA_W and MAX_LEN constants.
REQ-038 Sub-module dotp_mac_lane SHALL implement one lane: mode-dependent extension, multiply, mask and product register; it SHALL be instantiated LANES times.

Verification
REQ-039 Signed, len=8, a=1..8, b={10,10,10,10,1,1,1,1} -> result 126, done exactly 2 cycles after the 4th beat.
REQ-040 Signed, len=8, a={10,-5,100,-1,0,20,-2,1}, b={2,10,-1,20,50,-5,4,-8} -> result -266, overflow 0.
REQ-041 len=5, a=b={1,2,3,4,5} plus garbage 99 in lane 1 of beat 3 -> result 55 (garbage masked); len=0 -> result 0, no beats accepted.
REQ-042 Unsigned, len=1, a=0xFFFFFFFF, b=2 -> result 0x1FFFFFFFE; same data with signed_mode=1 -> result -2.
REQ-043 DOTP_SAT_EN with ACC_W=16, signed, a=b={200,200} -> result 32767, overflow 1; without the macro -> result 14464.
REQ-044 rst=0 pulsed after 2 beats of a len=8 operation -> all outputs 0, no done; a following run of the REQ-039 vectors with random in_valid gaps -> result 126.
